// File: rtl/floata_sched_if.sv
// Channel/converter bundle for the shared floata scheduler: requests, operands,
// completion pulses and the operand/result pair exchanged with the converter.
interface floata_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req;
  logic [16*NREQ-1:0] dq_in;
  logic [NREQ-1:0]    ack;
  logic [10:0]        dq0_out;
  logic [IDW-1:0]     gnt_id;
  logic               busy;
  logic [15:0]        conv_dq;
  logic [10:0]        conv_dq0;

  modport slave (
    input  req, dq_in, conv_dq0,
    output ack, dq0_out, gnt_id, busy, conv_dq
  );

  // Requesters plus the shared converter, seen from outside the scheduler.
  modport master (
    output req, dq_in, conv_dq0,
    input  ack, dq0_out, gnt_id, busy, conv_dq
  );
endinterface

// File: rtl/floata_sched.sv
// Round-robin scheduler sharing one 16-bit to 11-bit float converter among NREQ
// channels: grant, hold the operand for CONV_LAT cycles, capture, one-cycle ack.
module floata_sched #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int CONV_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic scan_in0,
  input  logic scan_in1,
  input  logic scan_in2,
  input  logic scan_in3,
  input  logic scan_in4,
  input  logic scan_enable,
  input  logic test_mode,
  output logic scan_out0,
  output logic scan_out1,
  output logic scan_out2,
  output logic scan_out3,
  output logic scan_out4,
  floata_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] ack_q;
  logic [10:0]     dq0_q;
  logic [IDW-1:0]  gnt_q;
  logic [IDW-1:0]  ptr_q;
  logic            busy_q;
  logic [15:0]     conv_dq_q;
  logic [2:0]      cnt_q;

  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic [15:0]     win_dq;
  logic [NREQ-1:0] gnt_onehot;
  logic            do_grant, do_capture, do_release;
  int              idx;

  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  logic unused_scan;
  assign unused_scan = &{1'b0, scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                         scan_enable, test_mode};

  // Walk from the highest rotated offset down so the last hit is the first
  // asserted request at or after the pointer.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (i == idx && bus.req[i]) begin
          win_found = 1'b1;
          win_id    = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    win_dq     = '0;
    gnt_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) win_dq = bus.dq_in[16*i +: 16];
      gnt_onehot[i] = (gnt_q == IDW'(i));
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_found) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    do_grant   = (state_q == IDLE) && win_found;
    do_capture = (state_q == WAIT) && (cnt_q == '0);
    do_release = (state_q == DONE);
  end

  // Reset wins over everything, including an in-flight capture, so an aborted
  // conversion never produces an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q     <= '0;
      dq0_q     <= '0;
      gnt_q     <= '0;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
      conv_dq_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (do_grant) begin
        conv_dq_q <= win_dq;
        gnt_q     <= win_id;
        busy_q    <= 1'b1;
        cnt_q     <= 3'(CONV_LAT - 1);
      end
      if (state_q == WAIT && cnt_q != '0) cnt_q <= cnt_q - 3'd1;
      if (do_capture) begin
        dq0_q  <= bus.conv_dq0;
        ack_q  <= gnt_onehot;
        busy_q <= 1'b0;
      end
      if (do_release) begin
        ack_q <= '0;
        ptr_q <= (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + IDW'(1);
      end
    end
  end

  assign bus.ack     = ack_q;
  assign bus.dq0_out = dq0_q;
  assign bus.gnt_id  = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.conv_dq = conv_dq_q;

endmodule
